dz_txscan: RTL and testbench
============================

# dz_txscan

DZ-11 transmitter scanner: the transmit-side counterpart of the receive SILO. Round-robin scans the eight asynchronous lines for one that is enabled (TCR) and whose UART transmitter is empty. Presents that line to the CSR logic as TRDY/TLINE, accepts the following TDR write, and issues a one-cycle load strobe with the character to the selected line's UART transmitter. Sits between the DZ CSR register file and the eight per-line UART transmitters.

## Interface
- NLINES, 8, number of lines scanned; fixed at 8 (TLINE is 3 bits)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clken  in  1  scan-rate clock enable; one line examined per asserted cycle
- mse  in  1  CSR master scan enable
- tcr  in  8  transmit control register; bit n enables line n
- uart_empty  in  8  bit n high when line n transmitter can accept a character
- tdr_wr  in  1  one-cycle strobe: CSR write to TDR
- tdr_data  in  8  character written to TDR
- trdy  out  1  transmitter ready; line in tline awaits a character
- tline  out  3  line number presented with trdy
- uart_load  out  8  one-hot, one-cycle load strobe to line n transmitter
- uart_data  out  8  character for uart_load; valid while uart_load nonzero

## Operation
- Reset (rst low, async): state=SCAN, scan counter=0, trdy=0, tline=0, uart_load=0, uart_data=0.
- SCAN
  - Acts only on cycles with clken=1. If mse=0: counter holds, no transition.
  - Line is eligible when mse & tcr[cnt] & uart_empty[cnt].
  - Eligible: tline<=cnt, trdy<=1, go READY. Counter holds.
  - Otherwise: cnt<=cnt+1 (3-bit, 7 wraps to 0).
- READY
  - trdy=1; tline stable. Independent of clken.
  - tdr_wr=1: uart_data<=tdr_data, trdy<=0, go LOAD. Takes priority over a same-cycle withdraw.
  - Otherwise, if mse=0 or tcr[tline]=0 (withdraw): trdy<=0, cnt<=tline+1, go SCAN.
- LOAD
  - uart_load[tline]=1 for exactly this cycle; uart_data holds the character.
  - Next cycle: uart_load=0, cnt<=tline+1, go SCAN. The round-robin resumes after the serviced line, so no line is starved.
  - uart_data holds its value until the next load. Not cleared.
- tdr_wr in SCAN or LOAD is ignored: no strobe, character discarded. This matches a DZ TDR write with TRDY clear.
- uart_empty is not rechecked in READY. The UART's emptiness cannot change without a load from this block.

## Timing
- Scan rate: one line per clken. An eligible line raises trdy on the clock edge of the clken cycle where cnt equals that line. Worst case is 8 clken cycles after the line becomes eligible.
- tdr_wr to uart_load: 1 clock. tdr_wr is sampled in cycle T; uart_load is asserted in cycle T+1. trdy falls in T+1.
- LOAD to next possible trdy: the next clken cycle after returning to SCAN (≥2 clocks after tdr_wr).
- Withdraw in READY: trdy falls on the next edge; scanning resumes at tline+1.
- Boundaries:
  - tline=7 service or withdraw: cnt wraps to 0.
  - All tcr=0: trdy stays 0 and cnt cycles 0..7 forever.
  - Reset asserted in READY or LOAD: trdy and uart_load drop immediately and asynchronously. A pending character is lost.

## Test plan
- Reset values: rst low with random inputs → trdy=0, tline=0, uart_load=0, uart_data=0. Release rst with mse=1, tcr=0x00, clken=1 → trdy stays 0 for 32 clocks.
- Single line: mse=1, tcr=0x20, uart_empty=0xFF, clken every cycle → trdy=1, tline=5 after the counter reaches 5. Then tdr_wr with 0x41 → next cycle uart_load=0x20, uart_data=0x41, trdy=0.
- Round-robin fairness: tcr=0xFF, uart_empty=0xFF, host writes TDR each time trdy is seen → tline sequence 0,1,2,…,7,0. Each uart_load is one-hot and matches tline.
- Withdraw: in READY with tline=3, clear tcr[3] → trdy falls next clock and no uart_load. Same cycle tdr_wr plus tcr[3] clear → load occurs (uart_load=0x08).
- Ignored write and mse: tdr_wr in SCAN → uart_load stays 0. In READY, drop mse → trdy falls. With mse=0, cnt holds and trdy never rises.
- Reset mid-operation: assert rst in the LOAD cycle → uart_load=0 immediately. After release, the scan restarts at line 0.

Source files
------------

// File: rtl/dz_txscan_if.sv
// Bus between the DZ CSR register file / per-line UART transmitters and the
// transmitter scanner. The master side drives scan controls and TDR writes.
interface dz_txscan_if;
    logic       clken;
    logic       mse;
    logic [7:0] tcr;
    logic [7:0] uart_empty;
    logic       tdr_wr;
    logic [7:0] tdr_data;
    logic       trdy;
    logic [2:0] tline;
    logic [7:0] uart_load;
    logic [7:0] uart_data;

    modport master (
        output clken, mse, tcr, uart_empty, tdr_wr, tdr_data,
        input  trdy, tline, uart_load, uart_data
    );

    modport slave (
        input  clken, mse, tcr, uart_empty, tdr_wr, tdr_data,
        output trdy, tline, uart_load, uart_data
    );
endinterface

// File: rtl/dz_txscan.sv
// DZ-11 transmitter scanner: round-robin search for an enabled, empty line,
// present it as TRDY/TLINE, and hand the next TDR write to that line's UART.
module dz_txscan (
    input  logic        clk,
    input  logic        rst,
    dz_txscan_if.slave  bus
);
    localparam int NLINES = 8;

    typedef enum logic [1:0] {
        S_SCAN  = 2'd0,
        S_READY = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [$clog2(NLINES)-1:0]   r_cnt, w_cnt_nxt;
    logic [$clog2(NLINES)-1:0]   r_tline, w_tline_nxt;
    logic [7:0]                  r_data, w_data_nxt;
    logic                        w_elig;
    logic                        w_withdraw;

    assign w_elig     = bus.mse & bus.tcr[r_cnt] & bus.uart_empty[r_cnt];
    assign w_withdraw = ~bus.mse | ~bus.tcr[r_tline];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tline_nxt = r_tline;
        w_data_nxt  = r_data;
        unique case (r_state)
            S_SCAN: begin
                if (bus.clken && bus.mse) begin
                    if (w_elig) begin
                        w_tline_nxt = r_cnt;
                        w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_READY: begin
                // A TDR write wins over a withdraw seen in the same cycle.
                if (bus.tdr_wr) begin
                    w_data_nxt  = bus.tdr_data;
                    w_state_nxt = S_LOAD;
                end else if (w_withdraw) begin
                    w_cnt_nxt   = r_tline + 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_LOAD: begin
                // Resume after the serviced line so every line gets its turn.
                w_cnt_nxt   = r_tline + 1'b1;
                w_state_nxt = S_SCAN;
            end
            default: begin
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_tline <= '0;
            r_data  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tline <= w_tline_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Outputs decode straight from state, so reset drops them asynchronously.
    assign bus.trdy      = (r_state == S_READY);
    assign bus.tline     = r_tline;
    assign bus.uart_load = (r_state == S_LOAD) ? (8'h01 << r_tline) : 8'h00;
    assign bus.uart_data = r_data;
endmodule

// File: tb/tb_dz_txscan.sv
// Self-checking bench for dz_txscan: directed scenarios with literal
// expectations plus randomized traffic compared against a line-service model.
module tb_dz_txscan;
    logic clk;
    logic rst;
    dz_txscan_if bus ();

    dz_txscan dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Model: which line is being served (-1 none), whether its character is
    // being handed over this cycle, and where the round-robin looks next.
    int         m_next;
    int         m_serving;
    bit         m_loading;
    int         m_tline;
    logic [7:0] m_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_next    = 0;
            m_serving = -1;
            m_loading = 0;
            m_tline   = 0;
            m_data    = 8'h00;
        end else if (m_loading) begin
            m_loading = 0;
            m_serving = -1;
            m_next    = (m_tline + 1) % 8;
        end else if (m_serving >= 0) begin
            if (bus.tdr_wr) begin
                m_data    = bus.tdr_data;
                m_loading = 1;
            end else if (!bus.mse || !bus.tcr[m_tline]) begin
                m_serving = -1;
                m_next    = (m_tline + 1) % 8;
            end
        end else if (bus.clken && bus.mse) begin
            if (bus.tcr[m_next] && bus.uart_empty[m_next]) begin
                m_serving = m_next;
                m_tline   = m_next;
            end else begin
                m_next = (m_next + 1) % 8;
            end
        end
    end

    // Compare process: outputs only change on posedge or reset, so sample on negedge.
    always @(negedge clk) begin
        logic [7:0] exp_load;
        exp_load = m_loading ? (8'h01 << m_tline) : 8'h00;
        check("model_trdy",      {31'd0, bus.trdy}, {31'd0, (m_serving >= 0) && !m_loading});
        check("model_tline",     {29'd0, bus.tline}, m_tline);
        check("model_uart_load", {24'd0, bus.uart_load}, {24'd0, exp_load});
        check("model_uart_data", {24'd0, bus.uart_data}, {24'd0, m_data});
    end

    task automatic drive(input logic ce, input logic m, input logic [7:0] t,
                         input logic [7:0] e, input logic w, input logic [7:0] d);
        bus.clken      = ce;
        bus.mse        = m;
        bus.tcr        = t;
        bus.uart_empty = e;
        bus.tdr_wr     = w;
        bus.tdr_data   = d;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_trdy(input int budget);
        int n;
        n = 0;
        while (!bus.trdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("trdy_within_budget", {31'd0, bus.trdy}, 32'd1);
    endtask

    // Write TDR while READY; returns on the LOAD cycle.
    task automatic write_tdr(input logic [7:0] d);
        bus.tdr_wr   = 1'b1;
        bus.tdr_data = d;
        @(negedge clk);
        bus.tdr_wr   = 1'b0;
    endtask

    initial begin
        int         prev;
        logic [7:0] ch;

        // Reset with random inputs.
        rst = 1'b0;
        drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        cycles(3);
        check("rst_trdy",      {31'd0, bus.trdy}, 32'd0);
        check("rst_tline",     {29'd0, bus.tline}, 32'd0);
        check("rst_uart_load", {24'd0, bus.uart_load}, 32'd0);
        check("rst_uart_data", {24'd0, bus.uart_data}, 32'd0);

        // All lines disabled: trdy never rises.
        drive(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 8'h00);
        rst = 1'b1;
        cycles(32);
        check("tcr0_trdy", {31'd0, bus.trdy}, 32'd0);

        // Single line 5.
        bus.tcr = 8'h20;
        wait_trdy(20);
        check("single_tline", {29'd0, bus.tline}, 32'd5);
        write_tdr(8'h41);
        check("single_load", {24'd0, bus.uart_load}, 32'h20);
        check("single_data", {24'd0, bus.uart_data}, 32'h41);
        check("single_trdy", {31'd0, bus.trdy}, 32'd0);
        @(negedge clk);
        check("single_load_one_cycle", {24'd0, bus.uart_load}, 32'h00);

        // Round-robin: resumes at line 6 after serving line 5.
        bus.tcr = 8'hFF;
        prev = 5;
        for (int k = 0; k < 10; k++) begin
            wait_trdy(20);
            check("rr_tline", {29'd0, bus.tline}, (prev + 1) % 8);
            prev = int'(bus.tline);
            ch = 8'($urandom);
            write_tdr(ch);
            check("rr_load_onehot", {24'd0, bus.uart_load}, 32'd1 << ((prev) % 8));
            check("rr_data", {24'd0, bus.uart_data}, {24'd0, ch});
        end

        // Withdraw line 3.
        bus.tcr = 8'h08;
        wait_trdy(20);
        check("wd_tline", {29'd0, bus.tline}, 32'd3);
        bus.tcr = 8'h00;
        @(negedge clk);
        check("wd_trdy", {31'd0, bus.trdy}, 32'd0);
        check("wd_noload", {24'd0, bus.uart_load}, 32'd0);
        // Write in the same cycle as the withdraw still loads.
        bus.tcr = 8'h08;
        wait_trdy(20);
        bus.tcr = 8'h00;
        write_tdr(8'h5A);
        check("wd_wr_load", {24'd0, bus.uart_load}, 32'h08);
        check("wd_wr_data", {24'd0, bus.uart_data}, 32'h5A);

        // Dropping mse in READY, then mse=0 keeps everything idle.
        bus.tcr = 8'h08;
        wait_trdy(20);
        bus.mse = 1'b0;
        @(negedge clk);
        check("mse_drop_trdy", {31'd0, bus.trdy}, 32'd0);
        bus.tcr = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            bus.tdr_wr = i[0];
            @(negedge clk);
            check("mse0_trdy", {31'd0, bus.trdy}, 32'd0);
            check("scan_wr_noload", {24'd0, bus.uart_load}, 32'd0);
        end
        bus.tdr_wr = 1'b0;

        // Reset asserted during LOAD.
        bus.mse = 1'b1;
        wait_trdy(20);
        write_tdr(8'hC3);
        check("pre_rst_load_active", {31'd0, bus.uart_load != 8'h00}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_load", {24'd0, bus.uart_load}, 32'd0);
        check("async_rst_trdy", {31'd0, bus.trdy}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        wait_trdy(20);
        check("post_rst_tline", {29'd0, bus.tline}, 32'd0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) != 0),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
